// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC mode encodings.
package pc_pkg;

  localparam int unsigned SelW = 3;

  localparam logic [SelW-1:0] INC_S  = 3'b000;
  localparam logic [SelW-1:0] IMM_S  = 3'b001;
  localparam logic [SelW-1:0] MEM_S  = 3'b010;
  localparam logic [SelW-1:0] REL_S  = 3'b011;
  localparam logic [SelW-1:0] CALL_S = 3'b100;
  localparam logic [SelW-1:0] RET_S  = 3'b101;
  localparam logic [SelW-1:0] HOLD_S = 3'b110;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// ovf/unf are single-cycle event indications, made sticky by the parent.
module pc_ras #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned PtrW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] FullCnt = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]  ptr_q, ptr_d, top_idx;
  logic [CntW-1:0]  count_q, count_d;

  // ptr_q is the next free slot; the top of stack sits just below it.
  assign top_idx = ptr_q - PtrOne;
  assign top     = mem_q[top_idx];
  assign empty   = (count_q == '0);
  assign full    = (count_q == FullCnt);
  assign ovf     = push & full;
  assign unf     = pop & empty;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + PtrOne;
      if (!full) begin
        count_d = count_q + CntOne;
      end
    end else if (pop && !empty) begin
      ptr_d   = top_idx;
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; a push held across reset is simply dropped.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, cnt register and sticky stack error
// flags around a circular return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] disp,
  input  logic             clr_err,
  output logic [WIDTH-1:0] cnt,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc, ras_top;
  logic             push, pop, ovf_evt, unf_evt;
  logic             ovf_q, ovf_d, unf_q, unf_d;

  assign cnt_inc = cnt_q + One;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (cnt_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ovf_evt),
    .unf       (unf_evt)
  );

  always_comb begin
    cnt_d = cnt_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (pc_en) begin
      case (sel)
        INC_S:   cnt_d = cnt_inc;
        IMM_S:   cnt_d = imm;
        MEM_S:   cnt_d = mem_addr;
        REL_S:   cnt_d = cnt_q + disp;
        CALL_S: begin
          cnt_d = imm;
          push  = 1'b1;
        end
        RET_S: begin
          pop = 1'b1;
          // Underflow leaves the PC where it is.
          if (!ras_empty) begin
            cnt_d = ras_top;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // A new error event beats a simultaneous clear.
  always_comb begin
    ovf_d = ovf_evt ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    unf_d = unf_evt ? 1'b1 : (clr_err ? 1'b0 : unf_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign cnt     = cnt_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, width of the program-counter and address datapath.
REQ-002 Parameter RAS_DEPTH, default 4, number of return-address-stack entries (power of two, >= 2).
REQ-003 Parameter RESET_VEC, default 0, value loaded into cnt on reset.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 pc_en  input  1  advance enable; when low, no state changes.
REQ-007 sel  input  3  next-PC mode select (encodings in REQ-011).
REQ-008 imm  input  WIDTH  absolute target for JMP and CALL.
REQ-009 mem_addr  input  WIDTH  absolute target for MEM mode.
REQ-010 disp  input  WIDTH  two's-complement displacement for REL mode.
REQ-011 Encodings: 000 INC, 001 IMM, 010 MEM, 011 REL, 100 CALL, 101 RET, 110/111 HOLD.
REQ-012 cnt  output  WIDTH  current program counter, registered.
REQ-013 ras_empty  output  1  stack holds zero entries, combinational from the occupancy count.
REQ-014 ras_full  output  1  stack holds RAS_DEPTH entries, combinational from the occupancy count.
REQ-015 ras_ovf  output  1  sticky flag: a CALL occurred while the stack was full.
REQ-016 ras_unf  output  1  sticky flag: a RET occurred while the stack was empty.
REQ-017 clr_err  input  1  synchronous clear of ras_ovf and ras_unf.

Function
REQ-018 With pc_en=1, the next-cycle cnt is selected by mode:
- INC: cnt+1
- IMM: imm
- MEM: mem_addr
- REL: cnt+disp
- CALL: imm
- RET: top of stack
- HOLD: cnt
REQ-019 All cnt arithmetic is modulo 2^WIDTH; INC at all-ones wraps to 0; REL wraps in both directions; no carry is reported.
REQ-020 CALL pushes cnt+1 (mod 2^WIDTH) and loads imm into cnt in the same edge; latency is one cycle.
REQ-021 RET loads the top-of-stack value into cnt and pops it in the same edge; latency is one cycle.
REQ-022 CALL when full: the push still occurs, the oldest entry is overwritten (circular), the occupancy count stays at RAS_DEPTH, and ras_ovf is set.
REQ-023 RET when empty: cnt holds, the occupancy count stays 0, and ras_unf is set.
REQ-024 pc_en=0: cnt, the stack, the pointer and the occupancy count hold for any sel; clr_err still acts.
REQ-025 clr_err=1 together with a new error event in the same cycle: the set wins, so the flag reads 1 after the edge.
REQ-026 Stack entries are WIDTH bits wide; push and pop never occur in the same cycle, because sel is one-hot in effect.
REQ-027 No combinational path exists from any input to cnt.

Reset
REQ-028 rst=0 asynchronously forces cnt=RESET_VEC, stack pointer=0, occupancy=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
REQ-029 Reset asserted mid-CALL or mid-RET discards that operation entirely; stack entry contents need not be cleared.
REQ-030 The first edge after rst deasserts with pc_en=1 and sel=INC yields cnt=RESET_VEC+1.

Structure
REQ-031 Shared package pc_pkg holds the sel encoding constants (INC_S, IMM_S, MEM_S, REL_S, CALL_S, RET_S, HOLD_S).
REQ-032 The return-address stack is a sub-module, pc_ras, with push, pop, push_data, top, empty, full, ovf and unf, parametrised by WIDTH and RAS_DEPTH.
REQ-033 pc_sequencer contains only the next-PC mux, the cnt register and the sticky error flags.

Verification
REQ-034 Reset, then 3 edges with pc_en=1, sel=INC -> cnt = 0, 1, 2, 3; with pc_en=0 for 2 edges -> cnt stays 3.
REQ-035 cnt=16'h0010, REL with disp=16'hFFFC -> cnt=16'h000C; cnt=16'hFFFF, INC -> cnt=16'h0000.
REQ-036 cnt=16'h0005, CALL imm=16'h0100, then RET -> cnt=16'h0100, then 16'h0006; ras_empty=1 at the end.
REQ-037 Five CALLs with RAS_DEPTH=4 (imm=16'h10..16'h14 from cnt=0) -> ras_full=1 and ras_ovf=1; four RETs return the last four return addresses in LIFO order; a fifth RET -> cnt holds and ras_unf=1.
REQ-038 clr_err=1 with no error event -> both flags clear the next edge; clr_err=1 together with a RET on empty -> ras_unf=1.
REQ-039 rst pulsed low between clock edges during a CALL -> cnt=RESET_VEC immediately, ras_empty=1, and no stack entry is visible afterwards.
